ifu_fetch_ctrl: RTL and testbench
=================================

Name: ifu_fetch_ctrl

Overview:
Instruction fetch unit directly upstream of the decode stage. It holds the PC and issues one fetch per instruction to instruction memory over a valid/ready request and response interface. It presents the fetched word plus its PC to decode with a valid/ready handshake, then waits for the commit pulse carrying dnpc before fetching again. Exactly one instruction is in flight at a time, and there is a sticky error state for bus errors, timeouts and misaligned targets.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset
TIMEOUT, 255, maximum cycles spent in WAIT before the error state is entered (8-bit counter)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request
imem_addr  out  32  fetch address, equal to the current PC
imem_resp_valid  in  1  response data valid
imem_rdata  in  32  fetched instruction word
imem_resp_err  in  1  bus error; qualified by imem_resp_valid
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts the instruction
out_inst  out  32  instruction word
out_pc  out  32  PC of out_inst
commit_valid  in  1  single-cycle pulse: instruction retired, dnpc valid
dnpc  in  32  next PC from execute
inst_cnt  out  32  count of committed instructions
fetch_err  out  1  sticky error flag

Behaviour:
- States: BOOT, REQ, WAIT, HOLD, EXEC, ERR. rst low forces BOOT asynchronously.
- Reset values:
  - pc=RESET_PC, out_inst=0, inst_cnt=0, fetch_err=0, timeout counter=0.
  - imem_req_valid=0, out_valid=0.
- BOOT: unconditionally moves to REQ on the next edge.
- REQ:
  - imem_req_valid=1 and imem_addr=pc.
  - If imem_req_ready=1, move to WAIT and clear the timeout counter. Otherwise stay in REQ with addr stable.
- WAIT:
  - imem_resp_valid is sampled only in this state; a response in REQ is ignored.
  - resp_valid & ~resp_err: latch imem_rdata into out_inst and move to HOLD.
  - resp_valid & resp_err: move to ERR.
  - No response: the counter increments; when counter==TIMEOUT, move to ERR.
- HOLD:
  - out_valid=1; out_inst and out_pc are held stable while out_ready=0.
  - out_ready=1 moves to EXEC.
- EXEC:
  - out_valid=0; wait for commit_valid.
  - On commit: inst_cnt+=1 (wraps 0xFFFFFFFF to 0).
  - If dnpc[1:0]==0: pc<=dnpc and move to REQ.
  - Otherwise: move to ERR; inst_cnt is still incremented and pc is unchanged.
- ERR:
  - fetch_err=1; imem_req_valid=0 and out_valid=0.
  - The state is held until rst is asserted.
- commit_valid outside EXEC is ignored: no pc or count change.
- out_pc always equals the pc register. The PC changes only on a valid EXEC commit.
- Minimum latency with memory ready at once and the response on the next cycle: REQ (cycle 0), WAIT (cycle 1), out_valid high in cycle 2.
- Reset asserted in any state, including mid-handshake, aborts the transaction. All outputs return to reset values immediately, and no pending response is consumed afterward.
- Widths: all PC arithmetic is 32-bit. The unit never computes pc+4 itself; dnpc is authoritative.

Test Plan:
1. Release reset with imem_req_ready=1 and a response 1 cycle later carrying 0x00000413 -> out_valid high 2 cycles after REQ, out_pc=0x80000000, out_inst=0x00000413.
2. Hold out_ready=0 for 5 cycles -> out_valid, out_inst and out_pc stay constant. Then out_ready=1 and commit with dnpc=0x80000004 -> next imem_addr=0x80000004 and inst_cnt=1.
3. In EXEC, commit with dnpc=0x80000006 -> fetch_err=1 and no further imem_req_valid. Pulse rst low -> pc=0x80000000 and fetch_err=0.
4. Keep imem_resp_valid=0 after request acceptance -> fetch_err rises exactly TIMEOUT+1 cycles after entering WAIT.
5. Response with imem_resp_err=1 -> ERR state with out_valid never asserted. Also drive a commit_valid pulse in HOLD -> pc and inst_cnt unchanged.
6. Assert rst while in WAIT, then drive a stale resp_valid after reset release -> the response is ignored and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifu_fetch_ctrl
//
// Instruction fetch controller that sits directly in front of decode. It keeps
// the PC and issues one instruction-memory fetch at a time. The fetched word
// and its PC are handed to decode, and the unit then waits for the commit
// pulse, whose dnpc becomes the next PC. Bus errors, response timeouts and
// misaligned commit targets all drop the unit into a sticky error state. Only
// reset leaves that state.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   imem_req_valid/ready     fetch request handshake
//   imem_addr                fetch address (always the current PC)
//   imem_resp_valid          response strobe, sampled only while waiting
//   imem_rdata/resp_err      response word and bus-error flag
//   out_valid/ready          instruction handshake towards decode
//   out_inst, out_pc         instruction word and the PC it was fetched from
//   commit_valid, dnpc       retire pulse and the next PC from execute
//   inst_cnt                 number of committed instructions (wrapping)
//   fetch_err                sticky error flag
// ---------------------------------------------------------------------------
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        commit_valid,
    input  logic [31:0] dnpc,
    output logic [31:0] inst_cnt,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        EXEC,
        ERR
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] inst_cnt_q;
    logic [31:0] inst_cnt_d;
    logic [7:0]  tmo_cnt_q;
    logic [7:0]  tmo_cnt_d;
    logic        req_valid_q;
    logic        out_valid_q;
    logic        err_q;

    // Counter increments are shared by the FSM below; both wrap naturally.
    assign inst_cnt_d = inst_cnt_q + 32'd1;
    assign tmo_cnt_d  = tmo_cnt_q + 8'd1;

    // Single FSM. The handshake outputs are registered, so every transition
    // also loads the output value that belongs to the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            inst_q      <= 32'd0;
            inst_cnt_q  <= 32'd0;
            tmo_cnt_q   <= 8'd0;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q     <= REQ;
                    req_valid_q <= 1'b1;
                end
                REQ: begin
                    // A response strobe here is ignored on purpose; only
                    // WAIT listens to the response channel.
                    if (imem_req_ready) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                        tmo_cnt_q   <= 8'd0;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (imem_resp_err) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= HOLD;
                            inst_q      <= imem_rdata;
                            out_valid_q <= 1'b1;
                        end
                    end else if (tmo_cnt_q == TIMEOUT_CNT) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= EXEC;
                        out_valid_q <= 1'b0;
                    end
                end
                EXEC: begin
                    // The retire is counted even when its target is
                    // misaligned; the PC keeps the faulting instruction.
                    if (commit_valid) begin
                        inst_cnt_q <= inst_cnt_d;
                        if (dnpc[1:0] == 2'b00) begin
                            pc_q        <= dnpc;
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    state_q     <= ERR;
                    req_valid_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    err_q       <= 1'b1;
                end
                default: begin
                    state_q     <= BOOT;
                    req_valid_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign out_valid      = out_valid_q;
    assign out_inst       = inst_q;
    assign out_pc         = pc_q;
    assign inst_cnt       = inst_cnt_q;
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch_ctrl
//
// Directed and randomized stimulus for ifu_fetch_ctrl. A transaction-level
// model tracks the PC, the committed-instruction count and the error flag.
// It updates them only from commit, error and reset events, and every
// observation is compared against that model.
// ---------------------------------------------------------------------------
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TIMEOUT  = 255;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;
    logic        imem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        commit_valid;
    logic [31:0] dnpc;
    logic [31:0] inst_cnt;
    logic        fetch_err;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] modelPc;
    logic [31:0] modelCnt;
    logic        modelErr;

    ifu_fetch_ctrl #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_rdata     (imem_rdata),
        .imem_resp_err  (imem_resp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .commit_valid   (commit_valid),
        .dnpc           (dnpc),
        .inst_cnt       (inst_cnt),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the sequence wedges.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare everything the model knows about.
    task automatic checkState(input string tag);
        checkOutput({tag, "_pc"},   out_pc,    modelPc);
        checkOutput({tag, "_addr"}, imem_addr, modelPc);
        checkOutput({tag, "_cnt"},  inst_cnt,  modelCnt);
        checkOutput({tag, "_err"},  {31'd0, fetch_err}, {31'd0, modelErr});
    endtask

    // Asynchronous reset pulse taken mid-cycle; other inputs are left as is.
    task automatic applyReset();
        rst = 1'b0;
        #2;
        modelPc  = RESET_PC;
        modelCnt = 32'd0;
        modelErr = 1'b0;
        checkState("rst_async");
        checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_inst",  out_inst, 32'd0);
        step();
        rst = 1'b1;
        step();
    endtask

    // One complete fetch from REQ through commit, with programmable stalls.
    task automatic applyStimulus(input logic [31:0] word, input logic [31:0] nextPc,
                                 input int reqDelay, input int respDelay,
                                 input int holdDelay, input bit holdCommit,
                                 input int execDelay);
        checkOutput("req_valid", {31'd0, imem_req_valid}, 32'd1);
        checkOutput("req_addr",  imem_addr, modelPc);
        for (int i = 0; i < reqDelay; i++) begin
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_err   = 1'($urandom_range(0, 1));
            imem_rdata      = $urandom;
            step();
            checkOutput("req_stall", {31'd0, imem_req_valid}, 32'd1);
        end
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        imem_req_ready  = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        checkOutput("wait_req_low", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 0; i < respDelay; i++) begin
            step();
            checkOutput("wait_out_low", {31'd0, out_valid}, 32'd0);
        end
        imem_resp_valid = 1'b1;
        imem_rdata      = word;
        step();
        imem_resp_valid = 1'b0;
        imem_rdata      = $urandom;
        checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_inst",  out_inst, word);
        checkOutput("hold_pc",    out_pc,   modelPc);
        for (int i = 0; i < holdDelay; i++) begin
            if (holdCommit && (i % 2 == 0)) begin
                commit_valid = 1'b1;
                dnpc         = $urandom;
            end
            step();
            commit_valid = 1'b0;
            checkOutput("hold_stable_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_stable_inst",  out_inst, word);
            checkState("hold_stable");
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("exec_out_low", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < execDelay; i++) begin
            step();
            checkOutput("exec_idle_req", {31'd0, imem_req_valid}, 32'd0);
            checkState("exec_idle");
        end
        commit_valid = 1'b1;
        dnpc         = nextPc;
        step();
        commit_valid = 1'b0;
        modelCnt = modelCnt + 32'd1;
        if (nextPc % 4 == 0) modelPc = nextPc;
        else                 modelErr = 1'b1;
        checkState("commit");
        checkOutput("commit_req", {31'd0, imem_req_valid}, {31'd0, !modelErr});
        checkOutput("commit_out", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] nextPc;

        rst             = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_rdata      = 32'd0;
        imem_resp_err   = 1'b0;
        out_ready       = 1'b0;
        commit_valid    = 1'b0;
        dnpc            = 32'd0;
        modelPc         = RESET_PC;
        modelCnt        = 32'd0;
        modelErr        = 1'b0;

        // Reset state
        step();
        step();
        checkState("reset");
        checkOutput("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_inst",  out_inst, 32'd0);
        rst = 1'b1;
        step();

        // Minimum latency fetch, hold for 5 cycles with stray commits, commit
        $display("[TB] directed fetch, hold and commit");
        applyStimulus(32'h0000_0413, 32'h8000_0004, 0, 0, 5, 1'b1, 0);
        checkOutput("t2_inst_cnt", inst_cnt, 32'd1);
        checkOutput("t2_addr", imem_addr, 32'h8000_0004);

        // Misaligned commit target enters the error state
        $display("[TB] misaligned dnpc");
        applyStimulus(32'h0010_0093, 32'h8000_0006, 1, 2, 1, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'b1;
            commit_valid   = 1'b1;
            dnpc           = 32'h8000_0100;
            step();
            checkOutput("err_no_req", {31'd0, imem_req_valid}, 32'd0);
            checkState("err_hold");
        end
        imem_req_ready = 1'b0;
        commit_valid   = 1'b0;
        applyReset();
        checkState("after_rst");

        // Response timeout
        $display("[TB] response timeout");
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        repeat (TIMEOUT) step();
        checkOutput("tmo_not_yet", {31'd0, fetch_err}, 32'd0);
        step();
        modelErr = 1'b1;
        checkState("tmo_err");
        checkOutput("tmo_req_low", {31'd0, imem_req_valid}, 32'd0);
        applyReset();

        // Bus error response
        $display("[TB] bus error response");
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b1;
        imem_rdata      = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        modelErr = 1'b1;
        checkState("buserr");
        checkOutput("buserr_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        checkOutput("buserr_out_valid2", {31'd0, out_valid}, 32'd0);
        applyReset();

        // Reset while waiting; the stale response must not be consumed
        $display("[TB] reset during WAIT");
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_rdata      = 32'hBAD0_BAD0;
        applyReset();
        repeat (2) begin
            step();
            checkOutput("stale_out_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("stale_req", {31'd0, imem_req_valid}, 32'd1);
            checkState("stale");
        end
        imem_resp_valid = 1'b0;
        applyStimulus(32'h1234_5678, 32'h8000_0040, 0, 1, 0, 1'b0, 0);

        // Randomized transactions
        $display("[TB] randomized transactions");
        for (int n = 0; n < 25; n++) begin
            word   = $urandom;
            nextPc = $urandom;
            nextPc[1:0] = 2'b00;
            applyStimulus(word, nextPc, $urandom_range(0, 3), $urandom_range(0, 4),
                          $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3));
        end
        checkOutput("final_cnt", inst_cnt, modelCnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
